// File: rtl/mitm_controller.sv
// mitm_controller: sequences sniffed SPI frames through the MITM decision logic.
// Each accepted frame is captured, handed to the logic with a one-cycle eval,
// and the logic's answer is loaded into the line transmitters once it signals done.
// Also tracks the chip-select transaction, counts frames, and flags overruns/timeouts.
module mitm_controller #(
    parameter int DATA_SIZE      = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 bus_active,
    input  logic                 byte_valid,
    input  logic [DATA_SIZE-1:0] real_mosi_data,
    input  logic [DATA_SIZE-1:0] real_miso_data,
    input  logic                 logic_done,
    input  logic [DATA_SIZE-1:0] logic_fake_miso_data,
    input  logic [DATA_SIZE-1:0] logic_fake_mosi_data,
    input  logic                 logic_fake_miso_select,
    input  logic                 logic_fake_mosi_select,
    output logic                 logic_eval,
    output logic [DATA_SIZE-1:0] captured_mosi_data,
    output logic [DATA_SIZE-1:0] captured_miso_data,
    output logic [DATA_SIZE-1:0] tx_miso_data,
    output logic [DATA_SIZE-1:0] tx_mosi_data,
    output logic                 tx_miso_select,
    output logic                 tx_mosi_select,
    output logic                 tx_load,
    output logic [CNT_WIDTH-1:0] byte_count,
    output logic                 overrun_err,
    output logic                 timeout_err,
    output logic                 busy
);

    // state      | meaning
    // STARTUP    | waiting for the logic to come out of reset (first done)
    // IDLE       | chip select inactive
    // ACTIVE     | transaction open, waiting for a frame
    // EVAL       | eval pulse presented to the logic
    // WAIT_DROP  | waiting for the stale done of the previous evaluation to fall
    // WAIT_DONE  | waiting for the logic to finish this evaluation
    localparam logic [2:0] ST_STARTUP   = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_ACTIVE    = 3'd2;
    localparam logic [2:0] ST_EVAL      = 3'd3;
    localparam logic [2:0] ST_WAIT_DROP = 3'd4;
    localparam logic [2:0] ST_WAIT_DONE = 3'd5;

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]           state_q, state_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                 abort_q, abort_d;
    logic                 logic_eval_q, logic_eval_d;
    logic [DATA_SIZE-1:0] cap_mosi_q, cap_mosi_d;
    logic [DATA_SIZE-1:0] cap_miso_q, cap_miso_d;
    logic [DATA_SIZE-1:0] tx_miso_data_q, tx_miso_data_d;
    logic [DATA_SIZE-1:0] tx_mosi_data_q, tx_mosi_data_d;
    logic                 tx_miso_sel_q, tx_miso_sel_d;
    logic                 tx_mosi_sel_q, tx_mosi_sel_d;
    logic                 tx_load_q, tx_load_d;
    logic [CNT_WIDTH-1:0] byte_count_q, byte_count_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic                 busy_q, busy_d;
    logic                 in_handshake;
    logic                 tmo_hit;
    logic                 do_timeout;

    // Next-state and output computation for the frame sequencer
    always_comb begin
        state_d        = state_q;
        tmo_cnt_d      = tmo_cnt_q;
        abort_d        = abort_q;
        logic_eval_d   = 1'b0;
        cap_mosi_d     = cap_mosi_q;
        cap_miso_d     = cap_miso_q;
        tx_miso_data_d = tx_miso_data_q;
        tx_mosi_data_d = tx_mosi_data_q;
        tx_miso_sel_d  = tx_miso_sel_q;
        tx_mosi_sel_d  = tx_mosi_sel_q;
        tx_load_d      = 1'b0;
        byte_count_d   = byte_count_q;
        overrun_d      = overrun_q;
        timeout_d      = timeout_q;
        do_timeout     = 1'b0;

        in_handshake = (state_q == ST_EVAL) || (state_q == ST_WAIT_DROP) ||
                       (state_q == ST_WAIT_DONE);
        tmo_hit      = ((state_q == ST_WAIT_DROP) || (state_q == ST_WAIT_DONE)) &&
                       (tmo_cnt_q == TMO_LAST);

        // A frame during the handshake is dropped; a chip-select drop poisons
        // this evaluation even if the bus comes back before done.
        if (in_handshake) begin
            if (byte_valid) begin
                overrun_d = 1'b1;
            end
            if (!bus_active) begin
                abort_d = 1'b1;
            end
        end
        if ((state_q == ST_WAIT_DROP) || (state_q == ST_WAIT_DONE)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end

        case (state_q)
            ST_STARTUP: begin
                if (logic_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                tx_miso_sel_d = 1'b0;
                tx_mosi_sel_d = 1'b0;
                if (bus_active) begin
                    byte_count_d = '0;
                    overrun_d    = 1'b0;
                    timeout_d    = 1'b0;
                    state_d      = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!bus_active) begin
                    tx_miso_sel_d = 1'b0;
                    tx_mosi_sel_d = 1'b0;
                    state_d       = ST_IDLE;
                end else if (byte_valid) begin
                    cap_mosi_d   = real_mosi_data;
                    cap_miso_d   = real_miso_data;
                    if (byte_count_q != '1) begin
                        byte_count_d = byte_count_q + CNT_WIDTH'(1);
                    end
                    logic_eval_d = 1'b1;
                    tmo_cnt_d    = '0;
                    state_d      = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_d = ST_WAIT_DROP;
            end
            ST_WAIT_DROP: begin
                if (!logic_done) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_hit) begin
                    do_timeout = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (logic_done) begin
                    if (!abort_q && bus_active) begin
                        tx_miso_data_d = logic_fake_miso_data;
                        tx_mosi_data_d = logic_fake_mosi_data;
                        tx_miso_sel_d  = logic_fake_miso_select;
                        tx_mosi_sel_d  = logic_fake_mosi_select;
                        tx_load_d      = 1'b1;
                        state_d        = ST_ACTIVE;
                    end else begin
                        tx_miso_sel_d = 1'b0;
                        tx_mosi_sel_d = 1'b0;
                        abort_d       = 1'b0;
                        state_d       = ST_IDLE;
                    end
                end else if (tmo_hit) begin
                    do_timeout = 1'b1;
                end
            end
            default: begin
                state_d = ST_STARTUP;
            end
        endcase

        // Timed-out evaluation: transmitters fall back to forwarding real data.
        if (do_timeout) begin
            timeout_d      = 1'b1;
            tx_miso_data_d = '0;
            tx_mosi_data_d = '0;
            tx_miso_sel_d  = 1'b0;
            tx_mosi_sel_d  = 1'b0;
            if (bus_active && !abort_q) begin
                tx_load_d = 1'b1;
                state_d   = ST_ACTIVE;
            end else begin
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
        end

        busy_d = (state_d == ST_STARTUP) || (state_d == ST_EVAL) ||
                 (state_d == ST_WAIT_DROP) || (state_d == ST_WAIT_DONE);
    end

    // State and registered outputs, cleared asynchronously on reset
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_STARTUP;
            tmo_cnt_q      <= '0;
            abort_q        <= 1'b0;
            logic_eval_q   <= 1'b0;
            cap_mosi_q     <= '0;
            cap_miso_q     <= '0;
            tx_miso_data_q <= '0;
            tx_mosi_data_q <= '0;
            tx_miso_sel_q  <= 1'b0;
            tx_mosi_sel_q  <= 1'b0;
            tx_load_q      <= 1'b0;
            byte_count_q   <= '0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmo_cnt_q      <= tmo_cnt_d;
            abort_q        <= abort_d;
            logic_eval_q   <= logic_eval_d;
            cap_mosi_q     <= cap_mosi_d;
            cap_miso_q     <= cap_miso_d;
            tx_miso_data_q <= tx_miso_data_d;
            tx_mosi_data_q <= tx_mosi_data_d;
            tx_miso_sel_q  <= tx_miso_sel_d;
            tx_mosi_sel_q  <= tx_mosi_sel_d;
            tx_load_q      <= tx_load_d;
            byte_count_q   <= byte_count_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
        end
    end

    assign logic_eval         = logic_eval_q;
    assign captured_mosi_data = cap_mosi_q;
    assign captured_miso_data = cap_miso_q;
    assign tx_miso_data       = tx_miso_data_q;
    assign tx_mosi_data       = tx_mosi_data_q;
    assign tx_miso_select     = tx_miso_sel_q;
    assign tx_mosi_select     = tx_mosi_sel_q;
    assign tx_load            = tx_load_q;
    assign byte_count         = byte_count_q;
    assign overrun_err        = overrun_q;
    assign timeout_err        = timeout_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_mitm_controller.sv
// Directed bench for mitm_controller with a small behavioural MITM logic model.
module tb_mitm_controller;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_active = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  real_mosi_data = 8'h00;
    logic [7:0]  real_miso_data = 8'h00;
    logic        logic_done;
    logic [7:0]  logic_fake_miso_data = 8'h00;
    logic [7:0]  logic_fake_mosi_data = 8'h00;
    logic        logic_fake_miso_select = 1'b0;
    logic        logic_fake_mosi_select = 1'b0;
    logic        logic_eval;
    logic [7:0]  captured_mosi_data;
    logic [7:0]  captured_miso_data;
    logic [7:0]  tx_miso_data;
    logic [7:0]  tx_mosi_data;
    logic        tx_miso_select;
    logic        tx_mosi_select;
    logic        tx_load;
    logic [15:0] byte_count;
    logic        overrun_err;
    logic        timeout_err;
    logic        busy;
    logic [54:0] out_vec;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int loads = 0;
    int first_load = -1;

    logic model_stuck = 1'b0;
    int   model_delay = 0;
    logic model_pend;
    int   model_dly;

    mitm_controller #(.DATA_SIZE(8), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)) dut (
        .sys_clk(sys_clk), .rst(rst), .bus_active(bus_active), .byte_valid(byte_valid),
        .real_mosi_data(real_mosi_data), .real_miso_data(real_miso_data),
        .logic_done(logic_done), .logic_fake_miso_data(logic_fake_miso_data),
        .logic_fake_mosi_data(logic_fake_mosi_data),
        .logic_fake_miso_select(logic_fake_miso_select),
        .logic_fake_mosi_select(logic_fake_mosi_select),
        .logic_eval(logic_eval), .captured_mosi_data(captured_mosi_data),
        .captured_miso_data(captured_miso_data), .tx_miso_data(tx_miso_data),
        .tx_mosi_data(tx_mosi_data), .tx_miso_select(tx_miso_select),
        .tx_mosi_select(tx_mosi_select), .tx_load(tx_load), .byte_count(byte_count),
        .overrun_err(overrun_err), .timeout_err(timeout_err), .busy(busy)
    );

    assign out_vec = {logic_eval, captured_mosi_data, captured_miso_data, tx_miso_data,
                      tx_mosi_data, tx_miso_select, tx_mosi_select, tx_load, byte_count,
                      overrun_err, timeout_err, busy};

    always #5 sys_clk = ~sys_clk;

    // MITM logic model: drops done the cycle after eval, raises it model_delay cycles later
    always @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            logic_done <= 1'b0;
            model_pend <= 1'b0;
            model_dly  <= 0;
        end else if (model_stuck) begin
            logic_done <= 1'b1;
        end else if (logic_eval) begin
            logic_done <= 1'b0;
            model_pend <= 1'b1;
            model_dly  <= model_delay;
        end else if (model_pend) begin
            if (model_dly == 0) begin
                logic_done <= 1'b1;
                model_pend <= 1'b0;
            end else begin
                model_dly <= model_dly - 1;
            end
        end else begin
            logic_done <= 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge sys_clk);
        cyc++;
        if (tx_load === 1'b1) begin
            loads++;
            if (first_load < 0) first_load = cyc;
        end
    endtask

    task automatic send_frame(input logic [7:0] mo, input logic [7:0] mi, output int c0);
        real_mosi_data = mo;
        real_miso_data = mi;
        byte_valid = 1'b1;
        c0 = cyc;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic start_txn();
        bus_active = 1'b0;
        tick();
        tick();
        bus_active = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        tests++;
        if (out_vec !== 55'd0) begin
            fails++; $display("FAIL reset_outputs: got %0h expected 0", out_vec);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL startup_busy: got %b expected 1", busy);
        end
        tick();
        tests++;
        if (out_vec !== 55'd0) begin
            fails++; $display("FAIL idle_outputs: got %0h expected 0", out_vec);
        end
    endtask

    task automatic test_single_frame();
        int c0;
        bus_active = 1'b1;
        tick(); tick();
        logic_fake_miso_select = 1'b1;
        logic_fake_miso_data   = 8'hA5;
        logic_fake_mosi_select = 1'b0;
        logic_fake_mosi_data   = 8'h5A;
        loads = 0; first_load = -1;
        send_frame(8'hA5, 8'h3C, c0);
        tests++;
        if (logic_eval !== 1'b1) begin
            fails++; $display("FAIL eval_pulse: got %b expected 1", logic_eval);
        end
        tests++;
        if ({captured_mosi_data, captured_miso_data} !== 16'hA53C) begin
            fails++; $display("FAIL captured: got %h%h expected a53c", captured_mosi_data, captured_miso_data);
        end
        tick();
        tests++;
        if (logic_eval !== 1'b0) begin
            fails++; $display("FAIL eval_one_cycle: got %b expected 0", logic_eval);
        end
        repeat (4) tick();
        tests++;
        if (first_load !== c0 + 4 || loads !== 1) begin
            fails++; $display("FAIL load_latency: got cycle %0d count %0d expected cycle %0d count 1", first_load - c0, loads, 4);
        end
        tests++;
        if ({tx_miso_data, tx_miso_select, tx_mosi_select, tx_mosi_data} !== {8'hA5, 1'b1, 1'b0, 8'h5A}) begin
            fails++; $display("FAIL tx_values: got %h %b %b %h expected a5 1 0 5a", tx_miso_data, tx_miso_select, tx_mosi_select, tx_mosi_data);
        end
        tests++;
        if (byte_count !== 16'd1 || busy !== 1'b0) begin
            fails++; $display("FAIL single_count: got count %0d busy %b expected 1 0", byte_count, busy);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        start_txn();
        tests++;
        if (byte_count !== 16'd0) begin
            fails++; $display("FAIL txn_start_clear: got %0d expected 0", byte_count);
        end
        loads = 0;
        for (int i = 0; i < 3; i++) begin
            logic_fake_miso_data = 8'h10 + 8'(i);
            send_frame(8'h20 + 8'(i), 8'h30 + 8'(i), c0);
            repeat (5) tick();
        end
        tests++;
        if (loads !== 3 || byte_count !== 16'd3 || overrun_err !== 1'b0) begin
            fails++; $display("FAIL back_to_back: got loads %0d count %0d ovr %b expected 3 3 0", loads, byte_count, overrun_err);
        end
        tests++;
        if (tx_miso_data !== 8'h12 || captured_mosi_data !== 8'h22) begin
            fails++; $display("FAIL back_to_back_data: got %h %h expected 12 22", tx_miso_data, captured_mosi_data);
        end
    endtask

    task automatic test_overrun();
        start_txn();
        loads = 0;
        real_mosi_data = 8'h44;
        byte_valid = 1'b1;
        tick(); tick();
        byte_valid = 1'b0;
        repeat (8) tick();
        tests++;
        if (overrun_err !== 1'b1 || byte_count !== 16'd1 || loads !== 1) begin
            fails++; $display("FAIL overrun: got ovr %b count %0d loads %0d expected 1 1 1", overrun_err, byte_count, loads);
        end
    endtask

    task automatic test_timeout();
        int c0;
        start_txn();
        logic_fake_miso_data = 8'hFF;
        logic_fake_mosi_data = 8'hEE;
        logic_fake_miso_select = 1'b1;
        logic_fake_mosi_select = 1'b1;
        model_stuck = 1'b1;
        loads = 0; first_load = -1;
        send_frame(8'h01, 8'h02, c0);
        repeat (19) tick();
        tests++;
        if (first_load !== c0 + 18 || loads !== 1) begin
            fails++; $display("FAIL timeout_load: got cycle %0d count %0d expected cycle 18 count 1", first_load - c0, loads);
        end
        tests++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL timeout_flag: got err %b busy %b expected 1 0", timeout_err, busy);
        end
        tests++;
        if ({tx_miso_data, tx_mosi_data, tx_miso_select, tx_mosi_select} !== 18'd0) begin
            fails++; $display("FAIL timeout_tx: got %h %h %b %b expected 0 0 0 0", tx_miso_data, tx_mosi_data, tx_miso_select, tx_mosi_select);
        end
        model_stuck = 1'b0;
        tick();
        send_frame(8'h03, 8'h04, c0);
        repeat (5) tick();
        tests++;
        if (loads !== 2 || tx_miso_data !== 8'hFF || byte_count !== 16'd2 || timeout_err !== 1'b1) begin
            fails++; $display("FAIL after_timeout: got loads %0d data %h count %0d err %b expected 2 ff 2 1", loads, tx_miso_data, byte_count, timeout_err);
        end
    endtask

    task automatic test_bus_drop();
        int c0;
        start_txn();
        logic_fake_miso_select = 1'b1;
        logic_fake_mosi_select = 1'b1;
        loads = 0;
        send_frame(8'h55, 8'h66, c0);
        repeat (5) tick();
        tests++;
        if (loads !== 1 || tx_miso_select !== 1'b1 || tx_mosi_select !== 1'b1) begin
            fails++; $display("FAIL drop_setup: got loads %0d sel %b%b expected 1 11", loads, tx_miso_select, tx_mosi_select);
        end
        send_frame(8'h57, 8'h68, c0);
        tick(); tick();
        bus_active = 1'b0;
        repeat (6) tick();
        tests++;
        if (loads !== 1 || {tx_miso_select, tx_mosi_select} !== 2'b00 || busy !== 1'b0 || byte_count !== 16'd2) begin
            fails++; $display("FAIL drop_wait_done: got loads %0d sel %b%b busy %b count %0d expected 1 00 0 2", loads, tx_miso_select, tx_mosi_select, busy, byte_count);
        end

        start_txn();
        loads = 0;
        send_frame(8'h71, 8'h72, c0);
        repeat (5) tick();
        model_delay = 4;
        send_frame(8'h73, 8'h74, c0);
        tick(); tick();
        bus_active = 1'b0;
        tick();
        bus_active = 1'b1;
        repeat (10) tick();
        tests++;
        if (loads !== 1 || {tx_miso_select, tx_mosi_select} !== 2'b00 || byte_count !== 16'd0 || busy !== 1'b0) begin
            fails++; $display("FAIL drop_and_return: got loads %0d sel %b%b count %0d busy %b expected 1 00 0 0", loads, tx_miso_select, tx_mosi_select, byte_count, busy);
        end
        model_delay = 0;
        send_frame(8'h75, 8'h76, c0);
        repeat (5) tick();
        tests++;
        if (loads !== 2 || byte_count !== 16'd1 || tx_miso_select !== 1'b1) begin
            fails++; $display("FAIL abort_cleared: got loads %0d count %0d sel %b expected 2 1 1", loads, byte_count, tx_miso_select);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        model_delay = 4;
        loads = 0;
        send_frame(8'h99, 8'h9A, c0);
        tick(); tick();
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL mid_busy: got %b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (out_vec !== 55'd0) begin
            fails++; $display("FAIL async_reset: got %0h expected 0", out_vec);
        end
        bus_active = 1'b0;
        model_delay = 0;
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL restart_busy: got %b expected 1", busy);
        end
        tick();
        tests++;
        if (out_vec !== 55'd0 || loads !== 0) begin
            fails++; $display("FAIL restart_idle: got %0h loads %0d expected 0 0", out_vec, loads);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_bus_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
